clm_acc_kn: RTL and testbench



---
 rtl/clm_pkg.sv | 41 ++++
 rtl/clm_lane_reduce.sv | 22 ++
 rtl/clm_acc_kn.sv | 127 ++++++++++++
 tb/tb_clm_acc_kn.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/clm_pkg.sv
// Shared definitions for the sign-corrected kernel accumulator.
// Holds the product width, lane-correction and saturating-add helpers, and the FSM state type.
// Everything here is pure combinational helpers and types.
package clm_pkg;

  localparam int PROD_W = 7;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // The multiplier delivers ~{0,m} for negative lanes, so sign-extending and
  // adding the sign bit turns the ones'-complement value into exact -m.
  function automatic logic signed [PROD_W:0] lane_corr(input logic sgn,
                                                       input logic [PROD_W-1:0] prod);
    return $signed({prod[PROD_W-1], prod}) + $signed({{PROD_W{1'b0}}, sgn});
  endfunction

  // Both operands are already within a w-bit signed range, so the 32-bit sum
  // is exact and only the clamp to w bits is needed.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

  function automatic logic sat_hit(input int a, input int b, input int w);
    int s;
    s = a + b;
    return (s > ((1 << (w - 1)) - 1)) || (s < -(1 << (w - 1)));
  endfunction

endpackage

// File: rtl/clm_lane_reduce.sv
// Combinational adder tree: corrects each lane's ones'-complement product and sums all lanes.
// Ports: i_sign (per-lane sign), i_prod (packed 7-bit products), o_sum (signed ACC_W-bit sum).
// Zero latency; no flow control (feeds the stage-1 register in clm_acc_kn).
module clm_lane_reduce
  import clm_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 12
) (
  input  logic [LANES-1:0]        i_sign,
  input  logic [PROD_W*LANES-1:0] i_prod,
  output logic signed [ACC_W-1:0] o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_sum = o_sum + ACC_W'(lane_corr(i_sign[i], i_prod[PROD_W*i +: PROD_W]));
    end
  end

endmodule

// File: rtl/clm_acc_kn.sv
// Kernel accumulator: sums LANES corrected products per beat over KLEN beats, saturating to ACC_W.
// Ports: in_* beat stream (valid/ready), out_* saturated window sum + overflow flag (valid/ready).
// Latency: last beat accepted at edge T -> out_valid after edge T+2; in_ready low from last beat to output handshake.
module clm_acc_kn
  import clm_pkg::*;
#(
  parameter int LANES = 4,
  parameter int KLEN  = 9,
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_sign,
  input  logic [PROD_W*LANES-1:0] in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_ovf
);

  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_in_rdy;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_s1_vld;
  logic                    r_s1_first;
  logic                    r_s1_last;
  logic signed [ACC_W-1:0] r_s1_sum;
  logic                    r_s2_last;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ovf;
  logic                    r_out_vld;
  logic [ACC_W-1:0]        r_out_data;
  logic                    r_out_ovf;

  logic signed [ACC_W-1:0] w_lane_sum;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    w_hit;
  logic                    w_fire;
  logic                    w_last;

  clm_lane_reduce #(
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_reduce (
    .i_sign (in_sign),
    .i_prod (in_prod),
    .o_sum  (w_lane_sum)
  );

  assign in_ready  = r_in_rdy;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  assign w_fire    = in_valid & r_in_rdy;
  assign w_last    = (r_cnt == CNT_LAST);

  // First beat of a window starts from zero rather than the stale accumulator.
  assign w_base    = r_s1_first ? '0 : r_acc;
  assign w_acc_nxt = ACC_W'(sat_add(32'(w_base), 32'(r_s1_sum), ACC_W));
  assign w_hit     = sat_hit(32'(w_base), 32'(r_s1_sum), ACC_W);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:   if (w_fire && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_s2_last)        w_state_nxt = ST_OUT;
      ST_OUT:   if (out_ready)        w_state_nxt = ST_ACC;
      default:                        w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ACC;
      r_in_rdy   <= 1'b0;
      r_cnt      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
      r_s2_last  <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Registered decode of the next state keeps in_ready free of any
      // combinational path from out_ready and low throughout reset.
      r_in_rdy <= (w_state_nxt == ST_ACC);

      if (w_fire) begin
        r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
        r_s1_sum   <= w_lane_sum;
        r_s1_first <= (r_cnt == '0);
        r_s1_last  <= w_last;
      end
      r_s1_vld <= w_fire;

      // Marks the cycle after stage 2 has absorbed the window's last beat.
      r_s2_last <= r_s1_vld & r_s1_last;

      if (r_s1_vld) begin
        r_acc <= w_acc_nxt;
        r_ovf <= (r_s1_first ? 1'b0 : r_ovf) | w_hit;
      end

      if (r_state == ST_DRAIN && r_s2_last) begin
        r_out_data <= r_acc;
        r_out_ovf  <= r_ovf;
        r_out_vld  <= 1'b1;
      end else if (r_state == ST_OUT && out_ready) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clm_acc_kn.sv
module tb_clm_acc_kn;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_sign;
  logic [27:0] in_prod;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_data;
  logic        in_ready9, out_valid9, out_ovf9;
  logic [8:0]  out_data9;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clm_acc_kn dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  clm_acc_kn #(.ACC_W(9)) dut9 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready9),
    .in_sign   (in_sign),
    .in_prod   (in_prod),
    .out_valid (out_valid9),
    .out_ready (out_ready),
    .out_data  (out_data9),
    .out_ovf   (out_ovf9)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    end
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic beat(input logic [3:0] s, input logic [27:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_wait_in_ready", {11'b0, in_ready}, 12'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_prod  = p;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_drop"}, {11'b0, out_valid}, 12'd0);
    chk({tag, "_rdy_back"}, {11'b0, in_ready}, 12'd1);
  endtask

  // Nine beats, then exact latency and result checks (leaves window in OUT).
  task automatic window(input string tag, input logic [3:0] s, input logic [27:0] p,
                        input logic [11:0] exp_d, input logic exp_o,
                        input logic do9, input logic [11:0] exp_d9, input logic exp_o9);
    for (int i = 0; i < 9; i++) beat(s, p);
    @(negedge clk);
    chk({tag, "_lat1"}, {11'b0, out_valid}, 12'd0);
    chk({tag, "_rdy_drain"}, {11'b0, in_ready}, 12'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, {11'b0, out_valid}, 12'd0);
    @(negedge clk);
    chk({tag, "_lat3"}, {11'b0, out_valid}, 12'd1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_ovf"}, {11'b0, out_ovf}, {11'b0, exp_o});
    if (do9) begin
      chk({tag, "_data9"}, {3'b0, out_data9}, exp_d9);
      chk({tag, "_ovf9"}, {11'b0, out_ovf9}, {11'b0, exp_o9});
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = '0;
    in_prod   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {11'b0, in_ready}, 12'd0);
    chk("rst_out_valid", {11'b0, out_valid}, 12'd0);
    chk("rst_out_data", out_data, 12'd0);
    chk("rst_out_ovf", {11'b0, out_ovf}, 12'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {11'b0, in_ready}, 12'd1);

    // All lanes +49: 4*49*9 = 1764; 9-bit copy saturates at 255
    window("pos49", 4'h0, {4{7'd49}}, 12'h6E4, 1'b0, 1'b1, 12'h0FF, 1'b1);
    handshake("pos49");

    // All lanes sign=1, prod=~49: -1764 (0x91C in 12 bits)
    window("neg49", 4'hF, {4{7'h4E}}, 12'h91C, 1'b0, 1'b0, 12'h0, 1'b0);
    handshake("neg49");

    // Zero products: result 0 and overflow flag cleared in the 9-bit copy
    window("zero", 4'h0, 28'h0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0);
    handshake("zero");

    // Mixed lanes (0,5),(1,~3),(0,0),(1,~0): +2 per beat -> 18
    window("mixed", 4'b1010, {7'h7F, 7'h00, 7'h7C, 7'd5}, 12'h012, 1'b0,
           1'b1, 12'h012, 1'b0);

    // Backpressure: hold output for 5 cycles with a beat offered upstream
    in_valid = 1'b1;
    in_sign  = 4'h0;
    in_prod  = {4{7'd63}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {11'b0, out_valid}, 12'd1);
      chk("hold_data", out_data, 12'h012);
      chk("hold_in_ready", {11'b0, in_ready}, 12'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_rel_vld", {11'b0, out_valid}, 12'd0);
    chk("hold_rel_rdy", {11'b0, in_ready}, 12'd1);

    // Window after backpressure: lane0 +1 per beat -> 9, offered beats never consumed
    window("after_hold", 4'h0, {21'd0, 7'd1}, 12'h009, 1'b0, 1'b0, 12'h0, 1'b0);
    handshake("after_hold");

    // Leave an output holding, then abort a partial window with reset
    window("pre_abort", 4'h0, {4{7'd2}}, 12'h048, 1'b0, 1'b0, 12'h0, 1'b0);
    handshake("pre_abort");
    for (int i = 0; i < 4; i++) beat(4'h0, {4{7'd49}});
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready", {11'b0, in_ready}, 12'd0);
    chk("abort_out_data", out_data, 12'd0);
    rst = 1'b0;

    window("abort", 4'h0, {21'd0, 7'd1}, 12'h009, 1'b0, 1'b1, 12'h009, 1'b0);
    handshake("abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
